// File: rtl/serial_multicaster_pkg.sv
// Shared types for the serial multicaster: header mode encoding and FSM states.
package multicast_pkg;

  typedef enum logic [1:0] {
    UNI   = 2'b00,
    GROUP = 2'b01,
    LINE  = 2'b10,
    BCAST = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    MODE,
    GADDR,
    LADDR,
    PAYLOAD
  } state_e;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_multicaster_if.sv
// Serial input handshake and fan-out line bus of the multicaster.
interface serial_multicaster_if #(
  parameter int N = 16
);
  logic         serIn;
  logic         ser_valid;
  logic         abort;
  logic [0:N-1] W;
  logic         valid;
  logic         busy;
  logic         done;

  modport master (output serIn, ser_valid, abort, input W, valid, busy, done);
  modport slave  (input serIn, ser_valid, abort, output W, valid, busy, done);
endinterface

// File: rtl/serial_multicaster_decoder.sv
// Combinational mode/group/line to output-line mask decode; bit g*LINES+l is line l of group g.
module line_mask_decoder
  import multicast_pkg::*;
#(
  parameter  int GROUPS = 4,
  parameter  int LINES  = 4,
  localparam int GW     = $clog2(GROUPS),
  localparam int LW     = $clog2(LINES),
  localparam int N      = GROUPS * LINES
) (
  input  mode_e         mode,
  input  logic [GW-1:0] g,
  input  logic [LW-1:0] l,
  output logic [0:N-1]  mask
);

  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
    for (genvar li = 0; li < LINES; li++) begin : g_line
      logic hit_g, hit_l;
      assign hit_g = (g == GW'(gi));
      assign hit_l = (l == LW'(li));
      assign mask[gi*LINES+li] = (mode == BCAST)
                               | ((mode == GROUP) & hit_g)
                               | ((mode == LINE)  & hit_l)
                               | ((mode == UNI)   & hit_g & hit_l);
    end
  end

endmodule

// File: rtl/serial_multicaster.sv
// Framed serial receiver that steers each payload bit onto one line, a group,
// a line index across groups, or all lines, with registered outputs.
module serial_multicaster
  import multicast_pkg::*;
#(
  parameter int GROUPS      = 4,
  parameter int LINES       = 4,
  parameter int PAYLOAD_LEN = 8
) (
  input logic clk,
  input logic rstn,
  serial_multicaster_if.slave bus
);

  localparam int GW = $clog2(GROUPS);
  localparam int LW = $clog2(LINES);
  localparam int N  = GROUPS * LINES;
  localparam int CW = $clog2(max2(max2(PAYLOAD_LEN, 2), max2(GW, LW)));

  state_e        state, state_nx, adv;
  logic [CW-1:0] cnt, cnt_nx, last;
  logic [1:0]    mode_q;
  logic [GW-1:0] g_q;
  logic [LW-1:0] l_q, l_full;
  logic [0:N-1]  mask_q, mask_nx;
  logic          accept, pay_bit, last_bit;

  // abort beats ser_valid: a bit presented with abort is never consumed
  assign accept   = bus.ser_valid & ~bus.abort;
  assign l_full   = LW'({l_q, bus.serIn});
  assign bus.busy = (state != IDLE);

  // decode sees the final line bit in flight so the mask is ready for payload
  line_mask_decoder #(.GROUPS(GROUPS), .LINES(LINES)) u_dec (
    .mode (mode_e'(mode_q)),
    .g    (g_q),
    .l    (l_full),
    .mask (mask_nx)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last     = '0;
    adv      = MODE;
    case (state)
      MODE:    begin last = CW'(1);             adv = GADDR;   end
      GADDR:   begin last = CW'(GW - 1);        adv = LADDR;   end
      LADDR:   begin last = CW'(LW - 1);        adv = PAYLOAD; end
      PAYLOAD: begin last = CW'(PAYLOAD_LEN-1); adv = IDLE;    end
      default: ;
    endcase
    if (accept) begin
      if (state == IDLE) begin
        if (bus.serIn) state_nx = MODE;
      end else if (cnt == last) begin
        state_nx = adv;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
    if (bus.abort) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
    pay_bit  = accept & (state == PAYLOAD);
    last_bit = pay_bit & (cnt == last);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q    <= '0;
      g_q       <= '0;
      l_q       <= '0;
      mask_q    <= '0;
      bus.W     <= '0;
      bus.valid <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      if (accept) begin
        case (state)
          MODE:  mode_q <= {mode_q[0], bus.serIn};
          GADDR: g_q    <= GW'({g_q, bus.serIn});
          LADDR: begin
            l_q <= l_full;
            if (cnt == last) mask_q <= mask_nx;
          end
          default: ;
        endcase
      end
      bus.W     <= pay_bit ? (mask_q & {N{bus.serIn}}) : '0;
      bus.valid <= pay_bit;
      bus.done  <= last_bit;
    end
  end

endmodule

// File: tb/tb_serial_multicaster.sv
// Randomized and directed bench for serial_multicaster against a frame-level reference model.
module tb_serial_multicaster;
  localparam int GROUPS = 4;
  localparam int LINES  = 4;
  localparam int PL     = 8;
  localparam int GW     = 2;
  localparam int LW     = 2;
  localparam int N      = GROUPS * LINES;
  localparam int HDR    = 2 + GW + LW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serial_multicaster_if #(.N(N)) bus ();

  serial_multicaster #(.GROUPS(GROUPS), .LINES(LINES), .PAYLOAD_LEN(PL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference model state: frame progress counted in accepted bits after the start bit
  bit           m_frame;
  int           m_cnt, m_mode, m_g, m_l;
  logic [0:N-1] e_w;
  logic         e_valid, e_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit sel(int mode, int g, int l, int i);
    case (mode)
      0: return i == g * LINES + l;
      1: return (i / LINES) == g;
      2: return (i % LINES) == l;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_frame = 0; m_cnt = 0; m_mode = 0; m_g = 0; m_l = 0;
    e_w = '0; e_valid = 0; e_done = 0;
  endtask

  task automatic model(input bit s, input bit v, input bit a);
    e_w = '0; e_valid = 0; e_done = 0;
    if (a) m_frame = 0;
    else if (v) begin
      if (!m_frame) begin
        if (s) begin m_frame = 1; m_cnt = 0; m_mode = 0; m_g = 0; m_l = 0; end
      end else begin
        if (m_cnt < 2) m_mode = m_mode * 2 + s;
        else if (m_cnt < 2 + GW) m_g = m_g * 2 + s;
        else if (m_cnt < HDR) m_l = m_l * 2 + s;
        else begin
          for (int i = 0; i < N; i++) e_w[i] = s & sel(m_mode, m_g, m_l, i);
          e_valid = 1;
          if (m_cnt - HDR == PL - 1) begin e_done = 1; m_frame = 0; end
        end
        m_cnt++;
      end
    end
  endtask

  task automatic step(input bit s, input bit v, input bit a);
    @(negedge clk);
    bus.serIn = s; bus.ser_valid = v; bus.abort = a;
    model(s, v, a);
    @(posedge clk);
    #1;
    chk("W", 64'(bus.W), 64'(e_w));
    chk("valid", 64'(bus.valid), 64'(e_valid));
    chk("busy", 64'(bus.busy), 64'(m_frame));
    chk("done", 64'(bus.done), 64'(e_done));
  endtask

  // gstall: one dropped cycle after first g bit; pstall cycles after 3rd payload bit
  task automatic send_frame(input int mode, input int g, input int l, input logic [PL-1:0] p,
                            input bit gstall, input int pstall);
    step(1, 1, 0);
    for (int i = 1; i >= 0; i--) step(mode[i], 1, 0);
    for (int i = GW - 1; i >= 0; i--) begin
      step(g[i], 1, 0);
      if (gstall && i == GW - 1) step(1, 0, 0);
    end
    for (int i = LW - 1; i >= 0; i--) step(l[i], 1, 0);
    for (int i = PL - 1; i >= 0; i--) begin
      step(p[i], 1, 0);
      if (i == PL - 3) for (int k = 0; k < pstall; k++) step($urandom_range(0, 1), 0, 0);
    end
  endtask

  task automatic random_frame();
    bit q[$];
    int abort_at;
    int mode = $urandom_range(0, 3);
    int g = $urandom_range(0, GROUPS - 1);
    int l = $urandom_range(0, LINES - 1);
    logic [PL-1:0] p = PL'($urandom);
    q.push_back(1);
    for (int i = 1; i >= 0; i--) q.push_back(mode[i]);
    for (int i = GW - 1; i >= 0; i--) q.push_back(g[i]);
    for (int i = LW - 1; i >= 0; i--) q.push_back(l[i]);
    for (int i = PL - 1; i >= 0; i--) q.push_back(p[i]);
    abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, q.size() - 1)) : -1;
    for (int k = 0; k < $urandom_range(0, 2); k++) step(0, 1, 0);
    foreach (q[i]) begin
      while ($urandom_range(0, 3) == 0) step($urandom_range(0, 1), 0, 0);
      if (i == abort_at) begin step(q[i], 1, 1); break; end
      step(q[i], 1, 0);
    end
  endtask

  initial begin
    bus.serIn = 0; bus.ser_valid = 0; bus.abort = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_W", 64'(bus.W), 64'(0));
    chk("rst_valid", 64'(bus.valid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    @(negedge clk) rstn = 1;

    // idle noise, then unicast to line 9
    repeat (3) step(0, 1, 0);
    send_frame(0, 2, 1, 8'b10110011, 0, 0);
    // line multicast l=3, then group 1 back-to-back
    send_frame(2, 0, 3, 8'hFF, 0, 0);
    send_frame(1, 1, 0, 8'b11010110, 0, 0);
    // broadcast with stalls
    send_frame(3, 1, 2, 8'b10101010, 1, 2);

    // abort on the 4th payload bit, then a clean frame
    step(1, 1, 0);
    for (int i = 0; i < HDR; i++) step(i[0], 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    step(1, 1, 1);
    step(1, 0, 0);
    send_frame(0, 3, 3, 8'b01100101, 0, 0);

    // reset pulsed during LADDR
    step(1, 1, 0);
    for (int i = 0; i < 2 + GW + 1; i++) step(1, 1, 0);
    chk("pre_rst_busy", 64'(bus.busy), 64'(1));
    @(negedge clk);
    bus.ser_valid = 0;
    #2 rstn = 0;
    #1;
    chk("arst_W", 64'(bus.W), 64'(0));
    chk("arst_valid", 64'(bus.valid), 64'(0));
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_done", 64'(bus.done), 64'(0));
    model_reset();
    @(negedge clk) rstn = 1;
    send_frame(1, 2, 0, 8'b11100001, 0, 0);

    for (int f = 0; f < 40; f++) random_frame();
    repeat (PL + HDR + 2) step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_multicaster.md
# serial_multicaster

Parametrised, clocked successor to the combinational two-level broadcast demultiplexer. It receives a framed serial stream on `serIn`: a start bit, a mode field, a group address and a line address, then a fixed-length payload. It steers each payload bit onto one line, one group, one line-index across all groups, or every line of a `GROUPS*LINES`-wide output bus. It sits between the serial receive path and the per-line consumers.

## Interface
- `GROUPS`, default 4: number of line groups; power of two, ≥2.
- `LINES`, default 4: lines per group; power of two, ≥2.
- `PAYLOAD_LEN`, default 8: payload bits per frame; ≥1.
- Derived: `GW=$clog2(GROUPS)`, `LW=$clog2(LINES)`, `N=GROUPS*LINES`.

Ports:
- `clk  in  1`: single clock; all logic rising-edge.
- `rstn  in  1`: reset; asynchronous, active-low.
- `serIn  in  1`: serial data bit.
- `ser_valid  in  1`: `serIn` is consumed only in cycles where this is 1.
- `abort  in  1`: synchronous frame abort.
- `W  out  [0:N-1]`: registered line outputs; `W[g*LINES+l]` is line `l` of group `g`.
- `valid  out  1`: `W` carries a payload bit this cycle.
- `busy  out  1`: state is not `IDLE`.
- `done  out  1`: one-cycle pulse when the last payload bit is on `W`.

## Operation
- Frame, MSB first per field: start bit `1`, `mode[1:0]`, `g[GW-1:0]`, `l[LW-1:0]`, then `PAYLOAD_LEN` payload bits. Header length is fixed, 3+GW+LW bits (7 at defaults). Address fields are always sent, even when the mode ignores them.
- Modes:
  - `00` unicast: line `g*LINES+l`.
  - `01` group: all lines of group `g`.
  - `10` line: line `l` of every group.
  - `11` broadcast: all `N` lines.
- States: `IDLE → MODE → GADDR → LADDR → PAYLOAD → IDLE`.
- Each state advances only on accepted bits (`ser_valid=1`). A per-field bit counter moves to the next state after the field's last bit.
- In `IDLE`, an accepted `serIn=0` is ignored. An accepted `1` is the start bit and moves to `MODE`.
- The mask is computed once the address is complete and held for the whole payload.
- Per accepted payload bit `b`: next cycle `W = mask & {N{b}}` and `valid=1`.
- No accepted payload bit (stall): next cycle `W=0` and `valid=0`. The payload counter holds.
- After the `PAYLOAD_LEN`-th accepted payload bit, the state returns to `IDLE`.
- `abort=1` in any state returns to `IDLE` next cycle and clears counters.
  - No `done` is produced and the bit in that cycle is not accepted.
  - `abort` wins over `ser_valid`.
- Reset, including mid-frame: asynchronously `W=0`, `valid=0`, `busy=0`, `done=0`, state `IDLE`, counters 0. Any partial frame is discarded.

## Timing
- All outputs are registered.
- Latency from an accepted payload bit to `W`/`valid`: 1 cycle.
- `done` is asserted in the same cycle as the final `valid`.
- `busy` rises the cycle after the start bit is accepted. It falls the cycle after the last payload bit is accepted, which is the cycle where `done=1`.
- Back-to-back frames: a start bit may be accepted in the same cycle as `done=1`. That is the first `IDLE` cycle, so there are no gap cycles.
- Unstalled frame duration: 3+GW+LW+PAYLOAD_LEN accepted bits (15 at defaults).
- `ser_valid` may drop on any cycle, including mid-field. Field assembly resumes with no loss.

## Structure
- Shared package `multicast_pkg`:
  - `mode_e` enum: `UNI`, `GROUP`, `LINE`, `BCAST`.
  - `state_e` enum: `IDLE`, `MODE`, `GADDR`, `LADDR`, `PAYLOAD`.
- Sub-module `line_mask_decoder`: combinational. Inputs are mode, `g` and `l`, parametrised by `GROUPS`/`LINES`. Output is an `N`-bit one-hot or multi-hot mask.
- Top level holds the FSM, counters, header shift registers, the mask register and the output registers.

## Test plan
All scenarios use default parameters.

- **Unicast:** frame `1,00,10,01,10110011` with `ser_valid` held 1 → `W[9]` carries 1,0,1,1,0,0,1,1 on consecutive cycles with `valid=1`; all other `W` bits stay 0; `done` pulses with the 8th bit.
- **Line and group multicast:** mode `10`, `l=11`, payload all 1 → `W[3]`, `W[7]`, `W[11]`, `W[15]` are high for 8 cycles, others 0. Mode `01`, `g=01` → `W[4:7]` are driven.
- **Broadcast with stalls:** mode `11`, payload `10101010`, with `ser_valid` dropped for 2 cycles after the 3rd payload bit and once mid-`GADDR` → all 16 lines carry the pattern; `valid=0` and `W=0` on stall cycles; `done` arrives 2 cycles later than unstalled (3 cycles if the `GADDR` stall is counted).
- **Abort and reset:** `abort` on the 4th payload bit → `valid=0` next cycle, no `done`, and a following frame decodes correctly. A separate run with `rstn` pulsed low during `LADDR` → all outputs 0 immediately, `busy=0`.
- **Back-to-back and idle noise:** `0`s before the start bit are ignored. A second frame's start bit accepted in the `done` cycle → the second frame's first payload bit appears 8 cycles after the first frame's `done`.
